// File: rtl/peripheral_bus_pkg.sv
// Shared types and helpers for the peripheral bus arbiter: FSM states and
// transfer size encodings.
package peripheral_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      XFER  = 2'd2
   } state_t;

   localparam logic [1:0] SIZE_1B = 2'd0;
   localparam logic [1:0] SIZE_2B = 2'd1;
   localparam logic [1:0] SIZE_4B = 2'd2;
   localparam logic [1:0] SIZE_8B = 2'd3;

   function automatic logic [3:0] beats_from_size(input logic [1:0] size);
      case (size)
         SIZE_1B: return 4'd1;
         SIZE_2B: return 4'd2;
         SIZE_4B: return 4'd4;
         SIZE_8B: return 4'd8;
         default: return 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/peripheral_rr_picker.sv
// Combinational round-robin picker: first asserted request after 'last',
// wrapping past the top master back to master 0.
module peripheral_rr_picker #(
   parameter int unsigned NUM_MASTERS = 16,
   parameter int unsigned IW          = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] request,
   input  logic [IW-1:0]          last,
   output logic [NUM_MASTERS-1:0] winner,
   output logic [IW-1:0]          index
);

   logic found;

   always_comb begin
      winner = '0;
      index  = '0;
      found  = 1'b0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         int unsigned j;
         j = (32'(last) + i) % NUM_MASTERS;
         if (!found && request[j]) begin
            found     = 1'b1;
            winner[j] = 1'b1;
            index     = IW'(j);
         end
      end
   end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared peripheral bus:
// grants one master, tracks its burst beat by beat, aborts on timeouts.
module peripheral_bus_arbiter
   import peripheral_bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS   = 16,
   parameter int unsigned START_TIMEOUT = 8,
   parameter int unsigned WAIT_TIMEOUT  = 64
) (
   input  logic                   sig_clock,
   input  logic                   sig_reset,
   input  logic [NUM_MASTERS-1:0] sig_request,
   input  logic                   sig_start,
   input  logic [1:0]             sig_size,
   input  logic                   sig_read,
   input  logic                   sig_write,
   input  logic                   sig_wait,
   output logic [NUM_MASTERS-1:0] sig_grant,
   output logic                   sig_bip,
   output logic                   sig_error,
   output logic                   busy
);

   localparam int unsigned IW  = $clog2(NUM_MASTERS);
   localparam int unsigned SCW = $clog2(START_TIMEOUT + 1);
   localparam int unsigned WCW = $clog2(WAIT_TIMEOUT + 1);

   state_t                   state;
   logic [IW-1:0]            last;
   logic [IW-1:0]            owner;
   logic [IW-1:0]            win_index;
   logic [NUM_MASTERS-1:0]   win_grant;
   logic [SCW-1:0]           start_cnt;
   logic [WCW-1:0]           wait_cnt;
   logic [3:0]               remaining;
   logic [3:0]               beats;

   assign beats = beats_from_size(sig_size);
   assign busy  = (state != IDLE);

   peripheral_rr_picker #(
      .NUM_MASTERS(NUM_MASTERS),
      .IW         (IW)
   ) u_picker (
      .request(sig_request),
      .last   (last),
      .winner (win_grant),
      .index  (win_index)
   );

   always_ff @(posedge sig_clock) begin
      if (!sig_reset) begin
         state     <= IDLE;
         sig_grant <= '0;
         sig_bip   <= 1'b0;
         sig_error <= 1'b0;
         last      <= IW'(NUM_MASTERS - 1);
         owner     <= '0;
         start_cnt <= '0;
         wait_cnt  <= '0;
         remaining <= '0;
      end else begin
         sig_error <= 1'b0;
         case (state)
            IDLE: begin
               if (|sig_request) begin
                  sig_grant <= win_grant;
                  last      <= win_index;
                  owner     <= win_index;
                  start_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (sig_start) begin
                  // read==write covers both the "both set" and "neither set" illegal starts
                  if (sig_read == sig_write) begin
                     sig_error <= 1'b1;
                     sig_grant <= '0;
                     state     <= IDLE;
                  end else begin
                     remaining <= beats;
                     sig_bip   <= (beats > 4'd1);
                     wait_cnt  <= '0;
                     state     <= XFER;
                  end
               end else if (!sig_request[owner]) begin
                  sig_grant <= '0;
                  state     <= IDLE;
               end else if (start_cnt == SCW'(START_TIMEOUT - 1)) begin
                  sig_error <= 1'b1;
                  sig_grant <= '0;
                  state     <= IDLE;
               end else if (start_cnt != '1) begin
                  start_cnt <= start_cnt + SCW'(1);
               end
            end
            XFER: begin
               if (!sig_wait) begin
                  wait_cnt <= '0;
                  if (remaining == 4'd1) begin
                     sig_grant <= '0;
                     sig_bip   <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     remaining <= remaining - 4'd1;
                     sig_bip   <= (remaining > 4'd2);
                  end
               end else if (wait_cnt == WCW'(WAIT_TIMEOUT - 1)) begin
                  sig_error <= 1'b1;
                  sig_grant <= '0;
                  sig_bip   <= 1'b0;
                  state     <= IDLE;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: begin
               sig_grant <= '0;
               sig_bip   <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed self-checking bench for peripheral_bus_arbiter: reset, round robin,
// burst with stalls, wait/start timeouts, request drop, illegal start, reset mid-burst.
module tb_peripheral_bus_arbiter;

   logic        sig_clock = 1'b0;
   logic        sig_reset;
   logic [15:0] sig_request;
   logic        sig_start;
   logic [1:0]  sig_size;
   logic        sig_read;
   logic        sig_write;
   logic        sig_wait;
   logic [15:0] sig_grant;
   logic        sig_bip;
   logic        sig_error;
   logic        busy;

   int unsigned compared   = 0;
   int unsigned mismatched = 0;

   peripheral_bus_arbiter #(
      .NUM_MASTERS  (16),
      .START_TIMEOUT(8),
      .WAIT_TIMEOUT (64)
   ) dut (
      .sig_clock  (sig_clock),
      .sig_reset  (sig_reset),
      .sig_request(sig_request),
      .sig_start  (sig_start),
      .sig_size   (sig_size),
      .sig_read   (sig_read),
      .sig_write  (sig_write),
      .sig_wait   (sig_wait),
      .sig_grant  (sig_grant),
      .sig_bip    (sig_bip),
      .sig_error  (sig_error),
      .busy       (busy)
   );

   always #5 sig_clock = ~sig_clock;

   task automatic tick();
      @(posedge sig_clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      sig_reset   = 1'b0;
      sig_request = 16'hFFFF;
      sig_start   = 1'b0;
      sig_size    = 2'd0;
      sig_read    = 1'b0;
      sig_write   = 1'b0;
      sig_wait    = 1'b0;

      // reset held two cycles with all requests pending
      tick();
      check("rst_grant0", 32'(sig_grant), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_bip", 32'(sig_bip), 32'h0);
      check("rst_error", 32'(sig_error), 32'h0);
      tick();
      check("rst_grant1", 32'(sig_grant), 32'h0);
      sig_reset = 1'b1;
      tick();
      check("post_rst_grant", 32'(sig_grant), 32'h0001);
      check("post_rst_busy", 32'(busy), 32'h1);

      // round robin over all 16 masters, single-beat reads, no wait
      for (int unsigned m = 0; m < 16; m++) begin
         check("rr_grant", 32'(sig_grant), 32'h1 << m);
         sig_start = 1'b1; sig_size = 2'd0; sig_read = 1'b1; sig_write = 1'b0;
         tick();
         sig_start = 1'b0;
         check("rr_xfer_grant", 32'(sig_grant), 32'h1 << m);
         check("rr_xfer_bip", 32'(sig_bip), 32'h0);
         tick();
         check("rr_idle_grant", 32'(sig_grant), 32'h0);
         check("rr_idle_err", 32'(sig_error), 32'h0);
         tick();
      end
      check("rr_wrap", 32'(sig_grant), 32'h0001);

      // master 0 drops its request while granted: release without error
      sig_request = 16'h0008;
      tick();
      check("drop0_grant", 32'(sig_grant), 32'h0);
      check("drop0_err", 32'(sig_error), 32'h0);
      tick();
      check("m3_grant", 32'(sig_grant), 32'h0008);

      // 8-beat write, three stall cycles on beat 2
      sig_start = 1'b1; sig_size = 2'd3; sig_read = 1'b0; sig_write = 1'b1;
      tick();
      sig_start = 1'b0;
      for (int unsigned k = 1; k <= 11; k++) begin
         check("burst_grant", 32'(sig_grant), 32'h0008);
         check("burst_bip", 32'(sig_bip), (k <= 10) ? 32'h1 : 32'h0);
         sig_wait = (k >= 2 && k <= 4);
         tick();
      end
      sig_wait = 1'b0;
      check("burst_end_grant", 32'(sig_grant), 32'h0);
      check("burst_end_bip", 32'(sig_bip), 32'h0);
      check("burst_end_err", 32'(sig_error), 32'h0);
      tick();
      check("m3_regrant", 32'(sig_grant), 32'h0008);

      // wait timeout: slave stalls forever on the first beat
      sig_start = 1'b1; sig_size = 2'd0; sig_read = 1'b1; sig_write = 1'b0;
      tick();
      sig_start = 1'b0;
      sig_wait  = 1'b1;
      for (int unsigned k = 1; k <= 63; k++) begin
         check("wto_grant", 32'(sig_grant), 32'h0008);
         check("wto_err", 32'(sig_error), 32'h0);
         tick();
      end
      check("wto_grant64", 32'(sig_grant), 32'h0008);
      sig_request = 16'h0000;
      tick();
      sig_wait = 1'b0;
      check("wto_err_pulse", 32'(sig_error), 32'h1);
      check("wto_grant_drop", 32'(sig_grant), 32'h0);
      check("wto_busy", 32'(busy), 32'h0);
      tick();
      check("wto_err_once", 32'(sig_error), 32'h0);

      // start timeout on master 5
      sig_request = 16'h0020;
      tick();
      for (int unsigned k = 1; k <= 7; k++) begin
         check("sto_grant", 32'(sig_grant), 32'h0020);
         check("sto_err", 32'(sig_error), 32'h0);
         tick();
      end
      check("sto_grant8", 32'(sig_grant), 32'h0020);
      tick();
      check("sto_err_pulse", 32'(sig_error), 32'h1);
      check("sto_grant_drop", 32'(sig_grant), 32'h0);
      tick();
      check("sto_err_once", 32'(sig_error), 32'h0);
      check("m5_regrant", 32'(sig_grant), 32'h0020);

      // master 5 drops request after two cycles: release, no error
      tick();
      sig_request = 16'h0000;
      tick();
      check("drop5_grant", 32'(sig_grant), 32'h0);
      check("drop5_err", 32'(sig_error), 32'h0);
      tick();
      check("drop5_err2", 32'(sig_error), 32'h0);
      check("drop5_busy", 32'(busy), 32'h0);

      // illegal start with read and write both high
      sig_request = 16'h0040;
      tick();
      check("m6_grant", 32'(sig_grant), 32'h0040);
      sig_start = 1'b1; sig_read = 1'b1; sig_write = 1'b1;
      sig_request = 16'h0000;
      tick();
      sig_start = 1'b0; sig_write = 1'b0;
      check("rw_err", 32'(sig_error), 32'h1);
      check("rw_grant", 32'(sig_grant), 32'h0);
      tick();

      // reset during beat 4 of an 8-beat read
      sig_request = 16'h0002;
      tick();
      check("m1_grant", 32'(sig_grant), 32'h0002);
      sig_start = 1'b1; sig_size = 2'd3; sig_read = 1'b1;
      tick();
      sig_start = 1'b0;
      tick();
      tick();
      tick();
      check("mid_bip", 32'(sig_bip), 32'h1);
      sig_reset = 1'b0;
      tick();
      check("mid_rst_grant", 32'(sig_grant), 32'h0);
      check("mid_rst_bip", 32'(sig_bip), 32'h0);
      check("mid_rst_err", 32'(sig_error), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      sig_reset   = 1'b1;
      sig_request = 16'h0000;
      tick();
      check("final_grant", 32'(sig_grant), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/peripheral_bus_arbiter.md
Name: peripheral_bus_arbiter

Overview:
- Central arbiter and transfer sequencer for the shared 16-master peripheral bus: request/grant, addr/size/read/write/start, bip, 8-bit data, wait, error.
- Grants the bus to one requester at a time, using round-robin priority.
- Tracks the granted master's transfer beat by beat and drives sig_bip.
- Releases the grant on completion, or aborts with sig_error on a slave wait timeout or a missing start.

Parameters:
- NUM_MASTERS, 16, number of requesters; width of sig_request/sig_grant.
- START_TIMEOUT, 8, cycles a granted master may take to assert sig_start before the grant is revoked.
- WAIT_TIMEOUT, 64, maximum consecutive sig_wait cycles on a single beat before abort.

Ports:
- sig_clock  input  1  bus clock; all logic on rising edge.
- sig_reset  input  1  synchronous, active-low reset.
- sig_request  input  NUM_MASTERS  per-master bus request, level-held.
- sig_start  input  1  granted master's address phase strobe, one cycle.
- sig_size  input  2  transfer size, sampled with sig_start; beats = 1<<sig_size (1,2,4,8).
- sig_read  input  1  read transfer, sampled with sig_start.
- sig_write  input  1  write transfer, sampled with sig_start.
- sig_wait  input  1  slave stall; a beat completes on a cycle with sig_wait low.
- sig_grant  output  NUM_MASTERS  one-hot grant, or all zero.
- sig_bip  output  1  burst in progress: high during every data beat except the last.
- sig_error  output  1  one-cycle abort pulse.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface decision: one clock, sig_clock. Reset sig_reset is synchronous and active-low.
- Reset (sig_reset low at a clock edge):
  - state=IDLE, sig_grant=0, sig_bip=0, sig_error=0, busy=0.
  - Round-robin pointer last=NUM_MASTERS-1, so master 0 has first priority.
  - Reset mid-transfer aborts immediately with no error pulse.
- Round robin:
  - Search starts at (last+1) mod NUM_MASTERS and wraps past NUM_MASTERS-1 to 0.
  - The first asserted request wins; last is updated to the winner when the grant is issued.
- IDLE:
  - If sig_request is nonzero, register the winner's one-hot grant and go to GRANT; the grant is visible the cycle after the request is seen (1-cycle latency).
  - Otherwise remain in IDLE.
- GRANT (grant held, counter cnt counts cycles):
  - sig_start high: latch beats=1<<sig_size, go to XFER.
  - The granted master's request drops without start: drop grant and go to IDLE, with no error.
  - cnt reaches START_TIMEOUT-1 with no start: pulse sig_error, drop grant, go to IDLE.
  - sig_start with both sig_read and sig_write high, or both low: pulse sig_error, go to IDLE.
- XFER (data beats, starting the cycle after sig_start):
  - remaining counter = beats, 4 bits.
  - sig_bip = (remaining > 1).
  - A beat completes on a cycle with sig_wait=0: remaining decrements.
  - When the last beat completes (remaining==1, wait low): clear grant and go to IDLE. sig_bip falls with that beat.
  - Wait counter: increments while sig_wait=1 and resets on each completed beat. At WAIT_TIMEOUT-1 consecutive waits: pulse sig_error, clear grant, go to IDLE.
  - Request deassertion during XFER is ignored; the transfer runs to completion.
- Back-to-back transfers:
  - After a completion or abort, the next grant is issued one cycle later from IDLE (one idle bus cycle between owners).
  - The previous owner has the lowest priority in the next arbitration.
- sig_error is high for exactly one cycle per abort. It coincides with grant removal and is never asserted in IDLE.
- sig_grant is never multi-hot. It is never nonzero in IDLE, except that the new grant appears on the cycle the state leaves IDLE.
- Counters saturate; there is no wrap-around in the wait or start counters.

Decomposition:
- Package peripheral_bus_pkg holds:
  - the state enum (IDLE, GRANT, XFER);
  - the size encoding constants SIZE_1B..SIZE_8B;
  - a beats_from_size function.
- One sub-module, peripheral_rr_picker: purely combinational. Inputs are the request vector and the last pointer; outputs are the one-hot winner and its index. It is instantiated once.
- Counters and the FSM stay in peripheral_bus_arbiter.

Test Plan:
- Reset with requests pending: sig_reset low for 2 cycles with sig_request=16'hFFFF -> sig_grant=0 throughout. Grant 16'h0001 appears 1 cycle after reset release.
- Round robin: all 16 requests held; each master does start, size=0, no wait -> grants cycle 0x0001, 0x0002 ... 0x8000, then 0x0001, with one idle cycle between owners.
- Burst: master 3 granted, start with size=3, sig_wait high on beat 2 for 3 cycles -> bip high for beats 1-7, low on beat 8, grant held 8+3 cycles after start, then 0.
- Wait timeout: WAIT_TIMEOUT=64, sig_wait stuck high after start -> sig_error pulses once on the 64th wait cycle, grant drops the same cycle, state returns to IDLE.
- Start timeout and request drop: master 5 granted, no start for 8 cycles -> one error pulse and grant released. Repeat with request 5 dropped after 2 cycles -> grant released, no error.
- Reset mid-XFER: reset asserted during beat 4 of 8 -> next cycle grant=0, bip=0, error=0, busy=0.
